// File: rtl/decim_pkg.sv
// Shared constants and width helpers for the decimator slice.
// Build option DECIM_ROUND_EN selects round-half-up window averages instead of truncation.
package decim_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int DECIM_DEF      = 4;
    localparam int FIFO_DEPTH_DEF = 4;

    function automatic int acc_width(input int data_w, input int decim);
        return data_w + $clog2(decim);
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Added to the window sum before the shift; DECIM/2 gives round half up.
    function automatic int round_offset(input int decim);
`ifdef DECIM_ROUND_EN
        return decim / 2;
`else
        return 0;
`endif
    endfunction

    localparam int ACC_W_DEF = acc_width(DATA_W_DEF, DECIM_DEF);

endpackage

// File: rtl/sample_fifo_0.sv
// Small result FIFO: registered storage, combinational head read, count-based full/empty.
// A push while full is accepted only when a pop happens on the same edge.
module sample_fifo_0
    import decim_pkg::*;
#(
    parameter int WIDTH = DATA_W_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop_ready,
    output logic [WIDTH-1:0]              head_data,
    output logic                          head_valid,
    output logic                          full,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             pop;
    logic             push_ok;

    assign head_valid = (count_reg != '0);
    assign full       = (count_reg == CNT_W'(DEPTH));
    assign count      = count_reg;
    // Empty reads as zero so o_data has a defined value out of reset.
    assign head_data  = head_valid ? mem[rd_ptr_reg] : '0;

    assign pop     = head_valid && pop_ready;
    assign push_ok = push && (!full || pop);

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/decimator_0.sv
// Averages non-overlapping windows of DECIM samples and queues the results.
// Build option DECIM_ROUND_EN rounds each average half up instead of truncating.
module decimator_0
    import decim_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DECIM      = DECIM_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_W-1:0]                  i_data,
    input  logic                               i_valid,
    output logic [DATA_W-1:0]                  o_data,
    output logic                               o_valid,
    input  logic                               o_ready,
    output logic                               o_overflow,
    output logic [count_width(FIFO_DEPTH)-1:0] o_count
);

    localparam int SHIFT     = $clog2(DECIM);
    localparam int ACC_W     = acc_width(DATA_W, DECIM);
    localparam int ROUND_OFF = round_offset(DECIM);

    logic [ACC_W-1:0]  acc_reg;
    logic [SHIFT-1:0]  cnt_reg;
    logic              overflow_reg;
    logic [ACC_W-1:0]  sum;
    logic [DATA_W-1:0] result;
    logic              window_close;
    logic              fifo_full;

    assign window_close = i_valid && (cnt_reg == SHIFT'(DECIM - 1));
    // Sum of DECIM samples plus DECIM/2 still fits in ACC_W bits.
    assign sum    = acc_reg + ACC_W'(i_data) + ACC_W'(ROUND_OFF);
    assign result = sum[SHIFT +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg      <= '0;
            cnt_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (window_close) begin
                acc_reg <= '0;
                cnt_reg <= '0;
                if (fifo_full && !o_ready) overflow_reg <= 1'b1;
            end else if (i_valid) begin
                acc_reg <= acc_reg + ACC_W'(i_data);
                cnt_reg <= cnt_reg + SHIFT'(1);
            end
        end
    end

    assign o_overflow = overflow_reg;

    sample_fifo_0 #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (window_close),
        .push_data  (result),
        .pop_ready  (o_ready),
        .head_data  (o_data),
        .head_valid (o_valid),
        .full       (fifo_full),
        .count      (o_count)
    );

endmodule

// File: tb/tb_decimator_0.sv
// Directed self-checking bench for decimator_0 with default parameters.
module tb_decimator_0;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_data;
    logic       i_valid;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_ready;
    logic       o_overflow;
    logic [2:0] o_count;

    int checks   = 0;
    int failures = 0;

    decimator_0 dut (
        .clk        (clk),
        .rst        (rst),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_overflow (o_overflow),
        .o_count    (o_count)
    );

    always #5 clk = ~clk;

    task automatic step(input logic v, input logic [7:0] d, input logic rdy);
        i_valid = v;
        i_data  = d;
        o_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        rst = 1'b0;
    endtask

    logic [7:0] round_exp;
    logic [7:0] drain_exp [4];

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_data = '0; o_ready = 1'b0;
        do_reset();
        chk("reset_valid", o_valid, 0);
        chk("reset_count", o_count, 0);
        chk("reset_ovf", o_overflow, 0);
        chk("reset_data", o_data, 0);

        // Basic window average
        step(1'b1, 8'd10, 1'b1);
        step(1'b1, 8'd20, 1'b1);
        step(1'b1, 8'd30, 1'b1);
        chk("avg_not_yet", o_valid, 0);
        step(1'b1, 8'd40, 1'b1);
        chk("avg_valid", o_valid, 1);
        chk("avg_data", o_data, 25);
        step(1'b0, 8'd0, 1'b1);
        chk("avg_popped", o_valid, 0);

        // Truncation vs rounding
`ifdef DECIM_ROUND_EN
        round_exp = 8'd2;
`else
        round_exp = 8'd1;
`endif
        step(1'b1, 8'd1, 1'b1);
        step(1'b1, 8'd2, 1'b1);
        step(1'b1, 8'd2, 1'b1);
        step(1'b1, 8'd2, 1'b1);
        chk("round_data", o_data, round_exp);
        for (int k = 0; k < 4; k++) step(1'b1, 8'd255, 1'b1);
        chk("max_data", o_data, 255);
        chk("max_valid", o_valid, 1);
        step(1'b0, 8'd0, 1'b1);

        // Fill, overflow, drain
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 8'd100, 1'b0);
            if (k == 8)  chk("fill_cnt2", o_count, 2);
            if (k == 16) begin
                chk("fill_cnt4", o_count, 4);
                chk("fill_no_ovf", o_overflow, 0);
            end
        end
        chk("ovf_set", o_overflow, 1);
        chk("ovf_cnt", o_count, 4);
        for (int k = 0; k < 4; k++) begin
            chk("drain_data", o_data, 100);
            chk("drain_cnt", o_count, 4 - k);
            step(1'b0, 8'd0, 1'b1);
        end
        chk("drain_empty", o_valid, 0);
        chk("ovf_sticky", o_overflow, 1);

        // Push and pop while full
        do_reset();
        chk("rst_clears_ovf", o_overflow, 0);
        for (int w = 1; w <= 4; w++)
            for (int k = 0; k < 4; k++) step(1'b1, 8'(w * 10), 1'b0);
        chk("full_cnt", o_count, 4);
        chk("full_head", o_data, 10);
        step(1'b1, 8'd50, 1'b0);
        step(1'b1, 8'd50, 1'b0);
        step(1'b1, 8'd50, 1'b0);
        chk("stall_head", o_data, 10);
        step(1'b1, 8'd50, 1'b1);
        chk("pp_cnt", o_count, 4);
        chk("pp_ovf", o_overflow, 0);
        drain_exp[0] = 8'd20; drain_exp[1] = 8'd30;
        drain_exp[2] = 8'd40; drain_exp[3] = 8'd50;
        for (int k = 0; k < 4; k++) begin
            chk("pp_order", o_data, drain_exp[k]);
            step(1'b0, 8'd0, 1'b1);
        end
        chk("pp_empty", o_valid, 0);

        // Reset mid-window discards the partial sum
        step(1'b1, 8'd200, 1'b1);
        step(1'b1, 8'd200, 1'b1);
        rst = 1'b1;
        step(1'b1, 8'd200, 1'b1);
        rst = 1'b0;
        step(1'b1, 8'd8, 1'b1);
        step(1'b1, 8'd8, 1'b1);
        step(1'b1, 8'd8, 1'b1);
        chk("mid_rst_nodata", o_valid, 0);
        step(1'b1, 8'd8, 1'b1);
        chk("mid_rst_data", o_data, 8);
        chk("mid_rst_cnt", o_count, 1);
        step(1'b0, 8'd0, 1'b1);

        // Gaps in i_valid are ignored
        step(1'b1, 8'd4, 1'b1);
        step(1'b0, 8'd99, 1'b1);
        step(1'b1, 8'd4, 1'b1);
        step(1'b0, 8'd99, 1'b1);
        step(1'b1, 8'd4, 1'b1);
        chk("gap_not_yet", o_valid, 0);
        step(1'b1, 8'd4, 1'b1);
        chk("gap_valid", o_valid, 1);
        chk("gap_data", o_data, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
